// File: rtl/ipdc_host_if.sv
// rtl/ipdc_host_if.sv - command, pixel, controller and result signal bundle for ipdc_host
interface ipdc_host_if;
  logic        i_cmd_valid;
  logic [2:0]  i_cmd_mode;
  logic        o_cmd_ready;
  logic        i_pix_valid;
  logic [23:0] i_pix_data;
  logic        o_pix_ready;
  logic        o_op_valid;
  logic [2:0]  o_op_mode;
  logic        o_in_valid;
  logic [23:0] o_in_data;
  logic        i_in_ready;
  logic        i_out_valid;
  logic [23:0] i_out_data;
  logic        o_res_valid;
  logic [23:0] o_res_data;
  logic        o_res_last;
  logic        o_done;
  logic        o_err;
  logic        o_ycbcr;

  modport master (
    input  i_cmd_valid, i_cmd_mode, i_pix_valid, i_pix_data, i_in_ready,
           i_out_valid, i_out_data,
    output o_cmd_ready, o_pix_ready, o_op_valid, o_op_mode, o_in_valid,
           o_in_data, o_res_valid, o_res_data, o_res_last, o_done, o_err, o_ycbcr
  );

  modport slave (
    output i_cmd_valid, i_cmd_mode, i_pix_valid, i_pix_data, i_in_ready,
           i_out_valid, i_out_data,
    input  o_cmd_ready, o_pix_ready, o_op_valid, o_op_mode, o_in_valid,
           o_in_data, o_res_valid, o_res_data, o_res_last, o_done, o_err, o_ycbcr
  );
endinterface

// File: rtl/ipdc_host.sv
// rtl/ipdc_host.sv - host sequencer: issues ops, streams 64 pixels, collects 16 result beats
module ipdc_host #(
  parameter int TIMEOUT = 1023
) (
  input logic         i_clk,
  input logic         i_rst_n,
  ipdc_host_if.master bus
);
  localparam int TW = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {IDLE, ISSUE, LOAD, WAIT_DONE, COLLECT} state_t;

  state_t        state_q, state_d;
  logic [2:0]    mode_q, mode_d;
  logic [5:0]    pix_cnt_q, pix_cnt_d;
  logic [3:0]    beat_cnt_q, beat_cnt_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic          res_valid_q, res_valid_d;
  logic [23:0]   res_data_q, res_data_d;
  logic          res_last_q, res_last_d;
  logic          done_q, done_d;
  logic          err_q, err_d;
  logic          ycbcr_q, ycbcr_d;

  logic pix_xfer;
  logic tmo_hit;

  assign pix_xfer = (state_q == LOAD) && bus.i_pix_valid && bus.i_in_ready;
  // Expires on the TIMEOUT-th consecutive idle cycle in a waiting state.
  assign tmo_hit  = (tmo_q == TW'(TIMEOUT - 1));

  always_comb begin
    state_d     = state_q;
    mode_d      = mode_q;
    pix_cnt_d   = pix_cnt_q;
    beat_cnt_d  = beat_cnt_q;
    tmo_d       = tmo_q + TW'(1);
    res_valid_d = 1'b0;
    res_data_d  = res_data_q;
    res_last_d  = 1'b0;
    done_d      = 1'b0;
    err_d       = err_q;
    ycbcr_d     = ycbcr_q;

    case (state_q)
      IDLE: begin
        tmo_d      = '0;
        pix_cnt_d  = '0;
        beat_cnt_d = '0;
        if (bus.i_cmd_valid) begin
          mode_d  = bus.i_cmd_mode;
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        tmo_d = '0;
        case (mode_q)
          3'd0:                      state_d = LOAD;
          3'd1, 3'd2, 3'd3, 3'd4:    state_d = COLLECT;
          default:                   state_d = WAIT_DONE;
        endcase
      end
      LOAD: begin
        if (pix_xfer) begin
          tmo_d     = '0;
          pix_cnt_d = pix_cnt_q + 6'd1;
          if (pix_cnt_q == 6'd63) begin
            state_d = WAIT_DONE;
          end
        end else if (tmo_hit) begin
          err_d   = 1'b1;
          tmo_d   = '0;
          state_d = IDLE;
        end
      end
      WAIT_DONE: begin
        if (bus.i_out_valid) begin
          tmo_d   = '0;
          done_d  = 1'b1;
          state_d = IDLE;
          if (mode_q == 3'd6) ycbcr_d = 1'b1;
          if (mode_q == 3'd7) ycbcr_d = 1'b0;
        end else if (tmo_hit) begin
          err_d   = 1'b1;
          tmo_d   = '0;
          state_d = IDLE;
        end
      end
      COLLECT: begin
        // A beat landing on the expiry cycle wins: it clears the timer first.
        if (bus.i_out_valid) begin
          tmo_d       = '0;
          res_valid_d = 1'b1;
          res_data_d  = bus.i_out_data;
          beat_cnt_d  = beat_cnt_q + 4'd1;
          if (beat_cnt_q == 4'd15) begin
            res_last_d = 1'b1;
            done_d     = 1'b1;
            state_d    = IDLE;
          end
        end else if (tmo_hit) begin
          err_d   = 1'b1;
          tmo_d   = '0;
          state_d = IDLE;
        end
      end
      default: begin
        tmo_d   = '0;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q     <= IDLE;
      mode_q      <= 3'd0;
      pix_cnt_q   <= '0;
      beat_cnt_q  <= '0;
      tmo_q       <= '0;
      res_valid_q <= 1'b0;
      res_data_q  <= 24'd0;
      res_last_q  <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      ycbcr_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      mode_q      <= mode_d;
      pix_cnt_q   <= pix_cnt_d;
      beat_cnt_q  <= beat_cnt_d;
      tmo_q       <= tmo_d;
      res_valid_q <= res_valid_d;
      res_data_q  <= res_data_d;
      res_last_q  <= res_last_d;
      done_q      <= done_d;
      err_q       <= err_d;
      ycbcr_q     <= ycbcr_d;
    end
  end

  assign bus.o_cmd_ready = (state_q == IDLE);
  assign bus.o_op_valid  = (state_q == ISSUE);
  assign bus.o_op_mode   = mode_q;
  assign bus.o_in_valid  = (state_q == LOAD) && bus.i_pix_valid;
  assign bus.o_in_data   = bus.i_pix_data;
  assign bus.o_pix_ready = (state_q == LOAD) && bus.i_in_ready;
  assign bus.o_res_valid = res_valid_q;
  assign bus.o_res_data  = res_data_q;
  assign bus.o_res_last  = res_last_q;
  assign bus.o_done      = done_q;
  assign bus.o_err       = err_q;
  assign bus.o_ycbcr     = ycbcr_q;
endmodule
